// File: rtl/mc_main_fsm_pkg.sv
// mc_ctrl_pkg: state encoding, datapath select encodings and control bundle for the multicycle main FSM.
package mc_ctrl_pkg;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
    } state_t;

    localparam logic [1:0] SRCA_RN    = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       illegal;
    } ctrl_t;
endpackage

// File: rtl/mc_main_fsm_if.sv
// mc_main_fsm_if: instruction fields in, control strobes/selects out.
// mem_ready exists only when MC_MEM_STALL_EN is defined.
interface mc_main_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
`ifdef MC_MEM_STALL_EN
    logic       mem_ready;
`endif
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       Illegal;

`ifdef MC_MEM_STALL_EN
    modport master (input Op, Funct, mem_ready,
                    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal);
    modport slave (output Op, Funct, mem_ready,
                   input IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal);
`else
    modport master (input Op, Funct,
                    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal);
    modport slave (output Op, Funct,
                   input IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal);
`endif
endinterface

// File: rtl/mc_main_fsm_outdec.sv
// mc_fsm_outdec: Moore output decode, state -> control bundle; undefined encodings drive all zeros.
module mc_fsm_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.next_pc    = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
            end
            DECODE: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
            end
            MEMADR:   ctrl.alu_src_b = SRCB_IMM;
            MEMRD:    ctrl.adr_src = 1'b1;
            MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            MEMWR: begin
                ctrl.adr_src = 1'b1;
                ctrl.mem_w   = 1'b1;
            end
            EXECUTER: ctrl.alu_op = 1'b1;
            EXECUTEI: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = 1'b1;
            end
            ALUWB:    ctrl.reg_w = 1'b1;
            BRANCH: begin
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALU;
                ctrl.branch     = 1'b1;
            end
            UNKNOWN:  ctrl.illegal = 1'b1;
            default:  ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: multicycle ARM main control FSM (state register + next-state logic).
// Define MC_MEM_STALL_EN to hold FETCH/MEMRD/MEMWR until mem_ready.
module mc_main_fsm
    import mc_ctrl_pkg::*;
(
    input logic          clk,
    input logic          reset,
    mc_main_fsm_if.master bus
);
    state_t state, next;
    ctrl_t  ctrl;
    logic   ready;

`ifdef MC_MEM_STALL_EN
    assign ready = bus.mem_ready;
`else
    assign ready = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FETCH;
        else       state <= next;

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = ready ? DECODE : FETCH;
            DECODE:   next = bus.Op == 2'b00 ? (bus.Funct[5] ? EXECUTEI : EXECUTER) :
                             bus.Op == 2'b01 ? MEMADR :
                             bus.Op == 2'b10 ? BRANCH : UNKNOWN;
            MEMADR:   next = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:    next = ready ? MEMWB : MEMRD;
            MEMWR:    next = ready ? FETCH : MEMWR;
            EXECUTER: next = ALUWB;
            EXECUTEI: next = ALUWB;
            default:  next = FETCH;
        endcase
    end

    mc_fsm_outdec u_outdec (.state(state), .ctrl(ctrl));

    assign bus.IRWrite   = ctrl.ir_write;
    assign bus.AdrSrc    = ctrl.adr_src;
    assign bus.ALUSrcA   = ctrl.alu_src_a;
    assign bus.ALUSrcB   = ctrl.alu_src_b;
    assign bus.ResultSrc = ctrl.result_src;
    assign bus.ALUOp     = ctrl.alu_op;
    assign bus.NextPC    = ctrl.next_pc;
    assign bus.RegW      = ctrl.reg_w;
    assign bus.MemW      = ctrl.mem_w;
    assign bus.Branch    = ctrl.branch;
    assign bus.Illegal   = ctrl.illegal;
endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: table-driven, hand-sequenced and random instruction checks of mc_main_fsm.
// Stall checks are included when MC_MEM_STALL_EN is defined.
module tb_mc_main_fsm;
    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal}
    localparam logic [13:0] W_F   = {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] W_D   = {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] W_MA  = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] W_MR  = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] W_MWB = {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] W_MWR = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [13:0] W_ER  = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] W_EI  = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] W_AWB = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] W_BR  = {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [13:0] W_UNK = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    typedef struct {
        string             name;
        logic [1:0]        op;
        logic [5:0]        funct;
        int                len;
        logic [0:4][13:0]  seq;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [13:0] exp_q[$];
    vec_t tbl[6];

    mc_main_fsm_if bus();
    mc_main_fsm dut (.clk(clk), .reset(reset), .bus(bus.master));

    always #5 clk = ~clk;

    wire logic [13:0] obs = {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                             bus.ALUOp, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.Illegal};

    task automatic check(input logic [13:0] exp, input string nm);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: outputs %b, required %b", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: an instruction is a fixed list of phases chosen by its class.
    function automatic void model(input logic [1:0] op, input logic [5:0] f);
        exp_q = '{W_F, W_D};
        case (op)
            2'b00: begin exp_q.push_back(f[5] ? W_EI : W_ER); exp_q.push_back(W_AWB); end
            2'b01: begin
                exp_q.push_back(W_MA);
                if (f[0]) begin exp_q.push_back(W_MR); exp_q.push_back(W_MWB); end
                else exp_q.push_back(W_MWR);
            end
            2'b10: exp_q.push_back(W_BR);
            default: exp_q.push_back(W_UNK);
        endcase
    endfunction

    // Fields only matter on decision edges; elsewhere they are scrambled to expose non-Moore outputs.
    task automatic run(input logic [1:0] op, input logic [5:0] f, input string nm, input bit stall);
        int i = 0;
        while (i < exp_q.size()) begin
            bit rdy = 1'b1;
            if (exp_q[i] == W_D || exp_q[i] == W_MA) begin
                bus.Op = op;
                bus.Funct = f;
            end else begin
                bus.Op = 2'($urandom);
                bus.Funct = 6'($urandom);
            end
`ifdef MC_MEM_STALL_EN
            if (stall && (exp_q[i] == W_F || exp_q[i] == W_MR || exp_q[i] == W_MWR))
                rdy = $urandom_range(0, 2) != 0;
            bus.mem_ready = rdy;
`else
            rdy = rdy | stall;
`endif
            check(exp_q[i], $sformatf("%s[%0d]", nm, i));
            tick();
            if (rdy) i++;
        end
    endtask

    initial begin
        tbl[0] = '{"ldr",   2'b01, 6'b011001, 5, {W_F, W_D, W_MA, W_MR, W_MWB}};
        tbl[1] = '{"str",   2'b01, 6'b011000, 4, {W_F, W_D, W_MA, W_MWR, 14'd0}};
        tbl[2] = '{"add_r", 2'b00, 6'b001000, 4, {W_F, W_D, W_ER, W_AWB, 14'd0}};
        tbl[3] = '{"add_i", 2'b00, 6'b101000, 4, {W_F, W_D, W_EI, W_AWB, 14'd0}};
        tbl[4] = '{"b",     2'b10, 6'b100110, 3, {W_F, W_D, W_BR, 14'd0, 14'd0}};
        tbl[5] = '{"ill",   2'b11, 6'b010101, 3, {W_F, W_D, W_UNK, 14'd0, 14'd0}};

        reset = 1'b1;
        bus.Op = 2'b00;
        bus.Funct = 6'b0;
`ifdef MC_MEM_STALL_EN
        bus.mem_ready = 1'b1;
`endif
        repeat (3) begin
            @(negedge clk);
            check(W_F, "reset_hold");
        end
        reset = 1'b0;

        foreach (tbl[k]) begin
            exp_q.delete();
            for (int j = 0; j < tbl[k].len; j++) exp_q.push_back(tbl[k].seq[j]);
            run(tbl[k].op, tbl[k].funct, tbl[k].name, 1'b0);
        end
        check(W_F, "after_ill_fetch");

        // Reset asserted while MemW is high must drop it without waiting for an edge.
        bus.Op = 2'b01;
        bus.Funct = 6'b011000;
        check(W_F, "rst_str_f");
        tick();
        check(W_D, "rst_str_d");
        tick();
        check(W_MA, "rst_str_ma");
        tick();
        check(W_MWR, "rst_str_wr");
        #2 reset = 1'b1;
        #1 check(W_F, "rst_in_memwr");
        tick();
        check(W_F, "rst_held");
        reset = 1'b0;
        tick();
        check(W_D, "rst_release_d");
        tick();
        check(W_MA, "rst_release_ma");
        tick();
        check(W_MWR, "rst_release_wr");
        tick();

`ifdef MC_MEM_STALL_EN
        bus.Op = 2'b01;
        bus.Funct = 6'b011001;
        bus.mem_ready = 1'b1;
        check(W_F, "stall_f");
        tick();
        check(W_D, "stall_d");
        tick();
        check(W_MA, "stall_ma");
        tick();
        check(W_MR, "stall_mr");
        bus.mem_ready = 1'b0;
        repeat (4) begin
            tick();
            check(W_MR, "stall_mr_hold");
        end
        bus.mem_ready = 1'b1;
        tick();
        check(W_MWB, "stall_mwb");
        tick();
`endif

        for (int n = 0; n < 300; n++) begin
            logic [1:0] op = 2'($urandom);
            logic [5:0] f = 6'($urandom);
            model(op, f);
            run(op, f, $sformatf("rnd%0d_op%b_f%b", n, op, f), 1'b1);
        end
        check(W_F, "final_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
